// File: rtl/rf_pkg.sv
// Register-file writeback constants shared by the write arbiter and its producers.
package rf_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 64;
    localparam int unsigned NUM_WB_SRC = 3;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_LSU = 2'd1,
        WB_FPU = 2'd2
    } wb_src_e;

endpackage

// File: rtl/regfile_write_arbiter_decoder.sv
// Parameterised n-to-2^n one-hot decoder.
module regfile_write_arbiter_decoder #(
    parameter int unsigned InputSize = 5
) (
    input  logic [InputSize-1:0]      data_i,
    output logic [(1<<InputSize)-1:0] data_o
);

    always_comb begin
        data_o         = '0;
        data_o[data_i] = 1'b1;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NumReq producers,
// with a registered address/data/one-hot-enable output stage.
module regfile_write_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned NumReq           = NUM_WB_SRC,
    parameter int unsigned AddrWidth        = REG_ADDR_W,
    parameter int unsigned DataWidth        = XLEN,
    parameter bit          ZeroRegHardwired = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          stall_i,
    input  logic [NumReq-1:0]             req_valid_i,
    input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq*DataWidth-1:0]   req_data_i,
    output logic [NumReq-1:0]             req_ready_o,
    output logic                          wr_valid_o,
    output logic [AddrWidth-1:0]          wr_addr_o,
    output logic [DataWidth-1:0]          wr_data_o,
    output logic [(1<<AddrWidth)-1:0]     wr_en_o,
    output logic [((NumReq > 1) ? $clog2(NumReq) : 1)-1:0] grant_id_o
);

    localparam int unsigned IdW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned EnW = 1 << AddrWidth;

    // Returns {found, index} of the first valid requester scanning upward from ptr.
    function automatic logic [IdW:0] rr_select(input logic [NumReq-1:0] valid,
                                               input logic [IdW-1:0]    ptr);
        logic [IdW:0] res;
        int           k;
        res = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            k = int'(ptr) + i;
            if (k >= int'(NumReq)) begin
                k = k - int'(NumReq);
            end
            if (!res[IdW] && valid[k[IdW-1:0]]) begin
                res = {1'b1, k[IdW-1:0]};
            end
        end
        return res;
    endfunction

    logic [IdW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [AddrWidth-1:0] wr_addr_q, wr_addr_d;
    logic [DataWidth-1:0] wr_data_q, wr_data_d;
    logic [EnW-1:0]       wr_en_q, wr_en_d;
    logic [IdW-1:0]       grant_id_q, grant_id_d;

    logic [IdW:0]         sel;
    logic                 win_vld;
    logic [IdW-1:0]       win_idx;
    logic [AddrWidth-1:0] win_addr;
    logic [DataWidth-1:0] win_data;
    logic [EnW-1:0]       win_en;
    logic                 transfer;
    logic                 zero_write;

    assign sel      = rr_select(req_valid_i, rr_ptr_q);
    assign win_vld  = sel[IdW];
    assign win_idx  = sel[IdW-1:0];
    assign transfer = win_vld && !stall_i && !reset_i;

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int k = 0; k < int'(NumReq); k++) begin
            if (win_idx == IdW'(k)) begin
                win_addr = req_addr_i[k*AddrWidth +: AddrWidth];
                win_data = req_data_i[k*DataWidth +: DataWidth];
            end
        end
    end

    regfile_write_arbiter_decoder #(
        .InputSize (AddrWidth)
    ) u_decoder (
        .data_i (win_addr),
        .data_o (win_en)
    );

    assign zero_write = ZeroRegHardwired && (win_addr == '0);

    // Ready is the one-hot of the winner; the address-0 write is still acknowledged.
    always_comb begin
        req_ready_o = '0;
        if (transfer) begin
            req_ready_o[win_idx] = 1'b1;
        end
    end

    // Next state: idle/stalled cycles drop valid and enable but hold address, data and id.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        wr_valid_d = 1'b0;
        wr_en_d    = '0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        grant_id_d = grant_id_q;
        if (transfer) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = win_addr;
            wr_data_d  = win_data;
            grant_id_d = win_idx;
            wr_en_d    = zero_write ? '0 : win_en;
            rr_ptr_d   = (win_idx == IdW'(NumReq - 1)) ? '0 : win_idx + IdW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_ptr_q   <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= '0;
            grant_id_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign wr_valid_o = wr_valid_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;
    assign wr_en_o    = wr_en_q;
    assign grant_id_o = grant_id_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed plus randomized bench for regfile_write_arbiter; an integer-file and an
// FP-file instance share stimulus and are checked against a reference model.
module tb_regfile_write_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int EW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              stall = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*DW-1:0]   req_data = '0;

    logic [N-1:0]  ready_a, ready_b;
    logic          wv_a, wv_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a, data_b;
    logic [EW-1:0] en_a, en_b;
    logic [1:0]    gid_a, gid_b;

    regfile_write_arbiter #(
        .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .ZeroRegHardwired(1'b1)
    ) u_dut_int (
        .clk_i(clk), .reset_i(rst), .stall_i(stall),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_data_i(req_data),
        .req_ready_o(ready_a), .wr_valid_o(wv_a), .wr_addr_o(addr_a),
        .wr_data_o(data_a), .wr_en_o(en_a), .grant_id_o(gid_a)
    );

    regfile_write_arbiter #(
        .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .ZeroRegHardwired(1'b0)
    ) u_dut_fp (
        .clk_i(clk), .reset_i(rst), .stall_i(stall),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_data_i(req_data),
        .req_ready_o(ready_b), .wr_valid_o(wv_b), .wr_addr_o(addr_b),
        .wr_data_o(data_b), .wr_en_o(en_b), .grant_id_o(gid_b)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;

    // Reference model state
    int            m_ptr = 0;
    logic          m_wv = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    int            m_gid = 0;
    logic [EW-1:0] m_en_a = '0;
    logic [EW-1:0] m_en_b = '0;
    int            last_gid = -1;

    // Producers: a pending request is held stable until it is granted
    logic          pv[N];
    logic [AW-1:0] pa[N];
    logic [DW-1:0] pd[N];
    int            waitc[N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner();
        if (rst || stall) return -1;
        for (int i = 0; i < N; i++) begin
            if (pv[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_valid[k]          = pv[k];
            req_addr[k*AW +: AW]  = pa[k];
            req_data[k*DW +: DW]  = pd[k];
        end
    endtask

    task automatic check_outputs();
        chk("wr_valid_int", 64'(wv_a), 64'(m_wv));
        chk("wr_valid_fp",  64'(wv_b), 64'(m_wv));
        chk("wr_addr_int",  64'(addr_a), 64'(m_addr));
        chk("wr_addr_fp",   64'(addr_b), 64'(m_addr));
        chk("wr_data_int",  data_a, m_data);
        chk("wr_data_fp",   data_b, m_data);
        chk("grant_id_int", 64'(gid_a), 64'(m_gid));
        chk("grant_id_fp",  64'(gid_b), 64'(m_gid));
        chk("wr_en_int",    64'(en_a), 64'(m_en_a));
        chk("wr_en_fp",     64'(en_b), 64'(m_en_b));
        chk("wr_en_onehot", 64'($countones(en_a) <= 1 && $countones(en_b) <= 1), 64'(1));
    endtask

    // One clock: check combinational ready, clock the edge, update the model, check outputs.
    task automatic cycle();
        int w;
        logic [N-1:0] e;
        drive();
        #1;
        w = model_winner();
        e = '0;
        if (w >= 0) e[w] = 1'b1;
        chk("req_ready_int", 64'(ready_a), 64'(e));
        chk("req_ready_fp",  64'(ready_b), 64'(e));
        @(posedge clk);
        if (w >= 0) begin
            m_wv   = 1'b1;
            m_addr = pa[w];
            m_data = pd[w];
            m_gid  = w;
            m_en_b = EW'(1) << pa[w];
            m_en_a = (pa[w] == '0) ? '0 : m_en_b;
            m_ptr  = (w + 1) % N;
            chk("starvation_bound", 64'(waitc[w] < N), 64'(1));
        end else begin
            m_wv   = 1'b0;
            m_en_a = '0;
            m_en_b = '0;
        end
        for (int k = 0; k < N; k++) begin
            if (k == w) waitc[k] = 0;
            else if (pv[k] && !stall) waitc[k]++;
        end
        if (w >= 0) pv[w] = 1'b0;
        last_gid = w;
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_ptr = 0; m_wv = 1'b0; m_addr = '0; m_data = '0; m_gid = 0;
        m_en_a = '0; m_en_b = '0;
        chk("reset_ready_int", 64'(ready_a), 64'(0));
        chk("reset_ready_fp",  64'(ready_b), 64'(0));
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N; k++) waitc[k] = 0;
    endtask

    task automatic refill(input int base);
        for (int k = 0; k < N; k++) begin
            if (!pv[k]) begin
                pv[k] = 1'b1;
                pa[k] = AW'(base + k + 1);
                pd[k] = {$urandom, $urandom};
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            pv[k] = 1'b1; pa[k] = AW'(k + 1); pd[k] = 64'(k) * 64'h1111; waitc[k] = 0;
        end
        drive();
        #2;
        // 1: reset with all valid, then first grant to req0
        do_reset();
        cycle();
        chk("t1_first_grant", 64'(last_gid), 64'(0));
        for (int k = 0; k < N; k++) pv[k] = 1'b0;
        cycle();

        // 2: single requester
        pv[1] = 1'b1; pa[1] = 5'd7; pd[1] = 64'hDEADBEEF;
        drive();
        #1;
        chk("t2_ready", 64'(ready_a), 64'(3'b010));
        cycle();
        chk("t2_wr_en", 64'(en_a), 64'(32'h0000_0080));
        chk("t2_gid", 64'(gid_a), 64'(1));
        chk("t2_valid", 64'(wv_a), 64'(1));

        // 3: move pointer to 0, then six fair grants
        pv[2] = 1'b1; pa[2] = 5'd9; pd[2] = 64'h99;
        cycle();
        for (int i = 0; i < 6; i++) begin
            refill(10 + 3 * i);
            cycle();
            chk("t3_order", 64'(last_gid), 64'(i % 3));
            chk("t3_en_addr", 64'(en_a), 64'(EW'(1) << addr_a));
        end

        // 4: zero register on req0
        refill(20);
        pa[0] = '0;
        drive();
        #1;
        chk("t4_ready", 64'(ready_a), 64'(3'b001));
        cycle();
        chk("t4_valid", 64'(wv_a), 64'(1));
        chk("t4_en_int", 64'(en_a), 64'(0));
        chk("t4_en_fp", 64'(en_b), 64'(32'h1));
        cycle();
        chk("t4_next_grant", 64'(last_gid), 64'(1));

        // 5: stall freezes the pointer
        refill(24);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t5_stall_valid", 64'(wv_a), 64'(0));
        end
        stall = 1'b0;
        cycle();
        chk("t5_resume", 64'(last_gid), 64'(2));

        // 6: reset drops the in-flight req2 request; pointer restarts at 0
        pv[0] = 1'b0; pv[1] = 1'b0; pv[2] = 1'b1; pa[2] = 5'd21; pd[2] = 64'h2121;
        drive();
        #1;
        chk("t6_ready", 64'(ready_a), 64'(3'b100));
        #1;
        do_reset();
        refill(26);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t6_order", 64'(last_gid), 64'(i));
        end

        // 7: randomized traffic with stalls and occasional resets
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) begin
                if (!pv[k] && $urandom_range(0, 1) == 1) begin
                    pv[k] = 1'b1;
                    pa[k] = AW'($urandom_range(0, 31));
                    pd[k] = {$urandom, $urandom};
                end
            end
            stall = ($urandom_range(0, 4) == 0);
            if (i % 137 == 100) begin
                stall = 1'b0;
                drive();
                #2;
                do_reset();
            end
            cycle();
        end
        stall = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
